// File: rtl/mem_access_unit.sv
// Data-memory bus initiator: one load/store in flight, byte-lane steering,
// waitrequest handling with a timeout, and aligned/extended load return.
module mem_access_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  mem_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        error,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic [31:0] bus_readdata,
    input  logic        bus_waitrequest
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic [CW-1:0] waitCnt_q, waitCnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [31:0]   loadData_q, loadData_d;
    logic [31:0]   busAddr_q, busAddr_d;
    logic          busRead_q, busRead_d;
    logic          busWrite_q, busWrite_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          reqIsByte, reqIsHalf, reqIsStore, reqMisaligned;
    logic [3:0]    reqBe;
    logic [31:0]   reqWdata;

    function automatic logic [31:0] extendLoad(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (op)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return rd;
            3'd3:    return {24'd0, b};
            3'd4:    return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    // Request decode: access size, lane enables and replicated store data.
    always_comb begin
        reqIsByte  = (mem_op == 3'd0) || (mem_op == 3'd3) || (mem_op == 3'd5);
        reqIsHalf  = (mem_op == 3'd1) || (mem_op == 3'd4) || (mem_op == 3'd6);
        reqIsStore = (mem_op >= 3'd5);
        if (reqIsByte) begin
            reqMisaligned = 1'b0;
            reqBe         = 4'b0001 << req_addr[1:0];
            reqWdata      = {4{req_wdata[7:0]}};
        end else if (reqIsHalf) begin
            reqMisaligned = req_addr[0];
            reqBe         = req_addr[1] ? 4'b1100 : 4'b0011;
            reqWdata      = {2{req_wdata[15:0]}};
        end else begin
            reqMisaligned = (req_addr[1:0] != 2'b00);
            reqBe         = 4'hF;
            reqWdata      = req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            lane_q     <= 2'd0;
            waitCnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            loadData_q <= 32'd0;
            busAddr_q  <= 32'd0;
            busRead_q  <= 1'b0;
            busWrite_q <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            waitCnt_q  <= waitCnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            loadData_q <= loadData_d;
            busAddr_q  <= busAddr_d;
            busRead_q  <= busRead_d;
            busWrite_q <= busWrite_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lane_d     = lane_q;
        waitCnt_d  = waitCnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        loadData_d = loadData_q;
        busAddr_d  = busAddr_q;
        busRead_d  = busRead_q;
        busWrite_d = busWrite_q;
        be_d       = be_q;
        wdata_d    = wdata_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req_valid) begin
                    op_d      = mem_op;
                    lane_d    = req_addr[1:0];
                    busAddr_d = {req_addr[31:2], 2'b00};
                    be_d      = reqBe;
                    wdata_d   = reqWdata;
                    waitCnt_d = '0;
                    busy_d    = 1'b1;
                    if (reqMisaligned) begin
                        done_d     = 1'b1;
                        error_d    = 1'b1;
                        loadData_d = 32'd0;
                        state_d    = DONE;
                    end else begin
                        busRead_d  = ~reqIsStore;
                        busWrite_d = reqIsStore;
                        state_d    = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!bus_waitrequest) begin
                    busRead_d  = 1'b0;
                    busWrite_d = 1'b0;
                    done_d     = 1'b1;
                    loadData_d = busRead_q ? extendLoad(op_q, lane_q, bus_readdata) : 32'd0;
                    state_d    = DONE;
                end else if (waitCnt_q == CW'(TIMEOUT - 1)) begin
                    // This stalled cycle is the TIMEOUT-th one, so abandon the access.
                    busRead_d  = 1'b0;
                    busWrite_d = 1'b0;
                    done_d     = 1'b1;
                    error_d    = 1'b1;
                    loadData_d = 32'd0;
                    state_d    = DONE;
                end else begin
                    waitCnt_d = waitCnt_q + CW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d     = 1'b0;
                busRead_d  = 1'b0;
                busWrite_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign load_data      = loadData_q;
    assign bus_address    = busAddr_q;
    assign bus_read       = busRead_q;
    assign bus_write      = busWrite_q;
    assign bus_byteenable = be_q;
    assign bus_writedata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus random
// transactions compared against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  mem_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        error;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_writedata;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_op(mem_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .load_data(load_data), .error(error), .bus_address(bus_address),
        .bus_read(bus_read), .bus_write(bus_write), .bus_byteenable(bus_byteenable),
        .bus_writedata(bus_writedata), .bus_readdata(bus_readdata),
        .bus_waitrequest(bus_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int opSize(input logic [2:0] op);
        case (op)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] sizeMask(input int size);
        if (size == 4) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * size)) - 32'd1;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] rd);
        int          size;
        logic [31:0] v;
        logic [31:0] m;
        size = opSize(op);
        m    = sizeMask(size);
        v    = (rd >> (8 * (addr % 4))) & m;
        if ((op == 3'd0 || op == 3'd1) && v[8 * size - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] op, input logic [31:0] wd);
        case (opSize(op))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int nWait);
        int          size;
        bit          store, misaligned, timedOut;
        int          expStrobes, k;
        logic [31:0] expLoad;
        logic [3:0]  expBe;

        size       = opSize(op);
        store      = (op >= 3'd5);
        misaligned = (addr % size) != 0;
        timedOut   = !misaligned && (nWait >= TO);
        expStrobes = timedOut ? TO : nWait + 1;
        expBe      = 4'(((1 << size) - 1) << (addr % 4));
        expLoad    = (store || misaligned || timedOut) ? 32'd0 : modelLoad(op, addr, rdata);

        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        req_valid       = 1'b1;
        mem_op          = op;
        req_addr        = addr;
        req_wdata       = wdata;
        bus_readdata    = rdata;
        bus_waitrequest = (nWait > 0);
        @(posedge clk);
        #1;
        mem_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        checkOutput("accept_busy", 32'(busy), 32'd1);

        if (misaligned) begin
            checkOutput("mis_done", 32'(done), 32'd1);
            checkOutput("mis_error", 32'(error), 32'd1);
            checkOutput("mis_strobes", {30'd0, bus_read, bus_write}, 32'd0);
        end else begin
            k = 0;
            while (!done && k <= TO + 2) begin
                checkOutput("strobe", {30'd0, bus_read, bus_write}, store ? 32'd1 : 32'd2);
                checkOutput("address", bus_address, addr & 32'hFFFF_FFFC);
                checkOutput("byteenable", 32'(bus_byteenable), 32'(expBe));
                if (store) checkOutput("writedata", bus_writedata, modelWdata(op, wdata));
                bus_waitrequest = (k < nWait);
                @(posedge clk);
                #1;
                k++;
            end
            checkOutput("strobe_cycles", 32'(k), 32'(expStrobes));
            checkOutput("done", 32'(done), 32'd1);
            checkOutput("error", 32'(error), 32'(timedOut));
            checkOutput("done_strobes", {30'd0, bus_read, bus_write}, 32'd0);
            checkOutput("done_busy", 32'(busy), 32'd1);
        end
        checkOutput("load_data", load_data, expLoad);

        // req_valid is still high here, so the DONE cycle must not accept it.
        bus_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("single_done", 32'(done), 32'd0);
        checkOutput("no_b2b_busy", 32'(busy), 32'd0);
        checkOutput("load_held", load_data, expLoad);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        int          nWait;

        reset           = 1'b1;
        req_valid       = 1'b0;
        mem_op          = 3'd0;
        req_addr        = 32'd0;
        req_wdata       = 32'd0;
        bus_readdata    = 32'd0;
        bus_waitrequest = 1'b0;
        #12;
        checkOutput("rst_flags", {28'd0, busy, done, error, bus_read}, 32'd0);
        checkOutput("rst_write", 32'(bus_write), 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        checkOutput("rst_addr", bus_address, 32'd0);
        checkOutput("rst_wdata", bus_writedata, 32'd0);
        checkOutput("rst_be", 32'(bus_byteenable), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3'd2, 32'h100, 32'd0, 32'hDEAD_BEEF, 0);
        applyStimulus(3'd0, 32'h103, 32'd0, 32'h8012_3456, 0);
        applyStimulus(3'd3, 32'h103, 32'd0, 32'h8012_3456, 0);
        applyStimulus(3'd6, 32'h202, 32'h0000_ABCD, 32'd0, 3);
        applyStimulus(3'd2, 32'h101, 32'd0, 32'hFFFF_FFFF, 0);
        applyStimulus(3'd2, 32'h400, 32'd0, 32'h1234_5678, 100);
        applyStimulus(3'd1, 32'h102, 32'd0, 32'h9ABC_0000, 1);
        applyStimulus(3'd4, 32'h102, 32'd0, 32'h9ABC_0000, 0);
        applyStimulus(3'd5, 32'h101, 32'h0000_00A5, 32'd0, 2);
        applyStimulus(3'd7, 32'h402, 32'h1111_2222, 32'd0, 0);

        // Reset in the middle of a stalled store.
        @(negedge clk);
        req_valid       = 1'b1;
        mem_op          = 3'd7;
        req_addr        = 32'h300;
        req_wdata       = 32'hCAFE_F00D;
        bus_waitrequest = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("pre_rst_write", 32'(bus_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_write", 32'(bus_write), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset           = 1'b0;
        bus_waitrequest = 1'b0;
        applyStimulus(3'd2, 32'h500, 32'd0, 32'h0BAD_CAFE, 0);

        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(opSize(op)) - 32'd1);
            nWait = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3);
            applyStimulus(op, addr, $urandom, $urandom, nWait);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
